sync_fifo: RTL and testbench

Single-clock first-in/first-out buffer of 8-bit words, default depth 8. It decouples a producer and a consumer running on the same clock and gives full/empty status plus early-warning almost_full/almost_empty flags for flow control. Writes and reads are qualified by enables and are silently ignored when they would overflow or underflow.

---
 rtl/sync_fifo_pkg.sv | 12 +
 rtl/sync_fifo_mem.sv | 35 +++
 rtl/sync_fifo.sv | 106 ++++++++++
 tb/tb_sync_fifo.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared constants and types for the sync_fifo slice.
//   FIFO_DATA_WIDTH : default word width in bits
//   FIFO_DEPTH      : default number of entries (power of two, >= 4)
//   fifo_word_t     : one word at the default width
package sync_fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 8;
  localparam int FIFO_DEPTH      = 8;

  typedef logic [FIFO_DATA_WIDTH-1:0] fifo_word_t;

endpackage : sync_fifo_pkg

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: DEPTH x DATA_WIDTH register array used as FIFO storage.
// Contents are not reset.
//   clk     : write clock
//   wr_en   : write strobe (already qualified by the caller)
//   wr_addr : write entry index
//   wr_data : write word
//   rd_addr : read entry index
//   rd_data : combinational read of entry rd_addr
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;

  // One enable per entry; each entry is an independent register.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    always_ff @(posedge clk) begin
      if (wr_en && (wr_addr == AW'(i))) mem[i] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule : sync_fifo_mem

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with full/empty and almost_full/almost_empty.
// Requests that would overflow/underflow are dropped without side effects.
// Optional macro SYNC_FIFO_ERR_FLAGS_EN adds sticky overflow/underflow outputs.
//   clk          : clock, rising edge
//   rst          : asynchronous active-low reset
//   wr_en        : write request, data_in sampled with it
//   data_in      : write word
//   rd_en        : read request
//   data_out     : registered read word, held until the next accepted read
//   full, empty  : count == DEPTH / count == 0
//   almost_full  : count >= DEPTH - AF_MARGIN
//   almost_empty : count <= AE_MARGIN
//   overflow     : (macro) sticky, wr_en while full
//   underflow    : (macro) sticky, rd_en while empty
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH,
  parameter int AF_MARGIN  = 1,
  parameter int AE_MARGIN  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_TH    = CW'(DEPTH - AF_MARGIN);
  localparam logic [CW-1:0] AE_TH    = CW'(AE_MARGIN);

  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  wr_ok, rd_ok;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  // Gating on the pre-edge flags gives the full/empty tie-break rules:
  // full+both takes only the read, empty+both takes only the write.
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_addr (rd_ptr),
    .rd_data (mem_rd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      data_out <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) begin
        rd_ptr   <= rd_ptr + AW'(1);
        data_out <= mem_rd_data;
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign full         = (count == CNT_FULL);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_TH);
  assign almost_empty = (count <= AE_TH);

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full)  overflow  <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  end
`endif

endmodule : sync_fifo

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed + random stimulus against a queue-based model.
module tb_sync_fifo;
  import sync_fifo_pkg::*;

  localparam int DEPTH = 8;
  localparam int AFM   = 1;
  localparam int AEM   = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en, rd_en;
  logic [7:0] data_in, data_out;
  logic       full, empty, almost_full, almost_empty;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic       overflow, underflow;
`endif

  sync_fifo #(
    .DATA_WIDTH (8),
    .DEPTH      (DEPTH),
    .AF_MARGIN  (AFM),
    .AE_MARGIN  (AEM)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .data_in      (data_in),
    .rd_en        (rd_en),
    .data_out     (data_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    .overflow     (overflow),
    .underflow    (underflow)
`endif
  );

  always #5 clk = ~clk;

  // Reference model
  fifo_word_t q[$];
  fifo_word_t exp_do;
  bit         exp_ovf, exp_unf;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    int n;
    n = q.size();
    check({ctx, ".count"},        32'(dut.count),       32'(n));
    check({ctx, ".empty"},        32'(empty),           32'(n == 0));
    check({ctx, ".full"},         32'(full),            32'(n == DEPTH));
    check({ctx, ".almost_full"},  32'(almost_full),     32'(n >= DEPTH - AFM));
    check({ctx, ".almost_empty"}, 32'(almost_empty),    32'(n <= AEM));
    check({ctx, ".data_out"},     32'(data_out),        32'(exp_do));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    check({ctx, ".overflow"},     32'(overflow),        32'(exp_ovf));
    check({ctx, ".underflow"},    32'(underflow),       32'(exp_unf));
`endif
  endtask

  // One clock: drive after negedge, model the edge, check #1 after posedge.
  task automatic step(input bit wr, input fifo_word_t din, input bit rd, input string ctx);
    bit was_full, was_empty;
    @(negedge clk);
    wr_en   = wr;
    rd_en   = rd;
    data_in = din;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    @(posedge clk);
    #1;
    if (wr && was_full)  exp_ovf = 1'b1;
    if (rd && was_empty) exp_unf = 1'b1;
    if (rd && !was_empty) exp_do = q.pop_front();
    if (wr && !was_full)  q.push_back(din);
    check_all(ctx);
  endtask

  task automatic model_reset();
    q.delete();
    exp_do  = '0;
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
  endtask

  initial begin
    wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;

    // Fill 01..08
    for (int i = 1; i <= DEPTH; i++) step(1'b1, fifo_word_t'(i), 1'b0, "fill");

    // Write while full: dropped
    step(1'b1, 8'h63, 1'b0, "overflow");

    // Drain: must come out 01..08
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b0, 8'h00, 1'b1, "drain");
      check("drain.order", 32'(data_out), 32'(i));
    end

    // Read while empty: data_out holds 08
    step(1'b0, 8'h00, 1'b1, "underflow");
    check("underflow.hold", 32'(data_out), 32'h08);

    // Simultaneous at count=3
    for (int i = 0; i < 3; i++) step(1'b1, fifo_word_t'(8'h10 + i), 1'b0, "pre3");
    for (int i = 0; i < 4; i++) begin
      step(1'b1, fifo_word_t'(8'h20 + i), 1'b1, "both3");
      check("both3.count", 32'(dut.count), 32'd3);
    end
    // Data order after simultaneous phase: 10,11,12 were read; 20..23 remain partially
    check("both3.lastread", 32'(data_out), 32'h20);

    // Drain to empty, then both at empty: only write taken, data_out unchanged
    while (q.size() > 0) step(1'b0, 8'h00, 1'b1, "drain2");
    step(1'b1, 8'hA5, 1'b1, "both0");
    check("both0.count", 32'(dut.count), 32'd1);
    check("both0.hold", 32'(data_out), 32'h23);

    // Fill to full then both while full: only the read is taken
    while (q.size() < DEPTH) step(1'b1, fifo_word_t'($urandom), 1'b0, "refill");
    step(1'b1, 8'h77, 1'b1, "bothfull");
    check("bothfull.count", 32'(dut.count), 32'(DEPTH - 1));

    // Random traffic
    for (int i = 0; i < 400; i++)
      step(1'(($urandom % 3) != 0), fifo_word_t'($urandom), 1'(($urandom % 2) != 0), "rand");

    // Ensure non-empty, then async reset between edges
    while (q.size() < 3) step(1'b1, fifo_word_t'($urandom), 1'b0, "prerst");
    step(1'b0, 8'h00, 1'b1, "prerst_rd");
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 8'h00, 1'b0, "post_rst_idle");
    step(1'b1, 8'h5A, 1'b0, "post_rst_wr");
    step(1'b0, 8'h00, 1'b1, "post_rst_rd");
    check("post_rst.data", 32'(data_out), 32'h5A);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule : tb_sync_fifo
